fixed_requant_round: RTL

- Downstream stage for the fixed-point activation blocks (softplus and similar), whose wide output carries extra fraction bits.
- Converts each lane from a wide fixed-point format to the narrower format the next layer expects.
- Per lane: round-half-up, arithmetic right shift, signed saturation.
- Two-stage valid/ready pipeline with full throughput, plus a sticky saturation event counter for debug/profiling.

---
 rtl/fixed_requant_round.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fixed_requant_round.sv
// fixed_requant_round: round-half-up, arithmetic shift and signed clip
// of wide fixed-point lanes through a two-stage valid/ready pipeline.
module fixed_requant_round #(
  parameter int DATA_IN_0_PRECISION_0       = 32,
  parameter int DATA_IN_0_PRECISION_1       = 15,
  parameter int DATA_OUT_0_PRECISION_0      = 16,
  parameter int DATA_OUT_0_PRECISION_1      = 8,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
  parameter int SAT_CNT_WIDTH               = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0] data_in_0
    [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0],
  input  logic data_in_0_valid,
  output logic data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0
    [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0],
  output logic data_out_0_valid,
  input  logic data_out_0_ready,
  input  logic sat_clear,
  output logic [SAT_CNT_WIDTH-1:0] sat_count
);

  localparam int N  = DATA_IN_0_PARALLELISM_DIM_0
                    * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int IW = DATA_IN_0_PRECISION_0;
  localparam int OW = DATA_OUT_0_PRECISION_0;
  localparam int SH = DATA_IN_0_PRECISION_1
                    - DATA_OUT_0_PRECISION_1;
  localparam int RW = IW + 1 - SH;
  localparam int CW = (RW > OW) ? RW : OW;
  localparam int PW = $clog2(N + 1);
  localparam int AW = ((SAT_CNT_WIDTH > PW) ? SAT_CNT_WIDTH : PW) + 1;
  localparam int BSH = (SH > 0) ? SH - 1 : 0;

  localparam logic signed [IW:0] BIAS =
    (IW+1)'((SH > 0) ? (64'd1 << BSH) : 64'd0);
  localparam logic signed [CW-1:0] MAX_W =
    {{(CW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [CW-1:0] MIN_W =
    {{(CW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  localparam logic [OW-1:0] MAX_O = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] MIN_O = {1'b1, {(OW-1){1'b0}}};
  localparam logic [AW-1:0] CNT_MAX =
    AW'({SAT_CNT_WIDTH{1'b1}});

  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_ready, s2_ready;
  logic s1_load, s2_load;

  logic signed [RW-1:0] s1_q [N-1:0];
  logic signed [RW-1:0] s1_d [N-1:0];
  logic [OW-1:0] dout_q [N-1:0];
  logic [OW-1:0] dout_d [N-1:0];
  logic [N-1:0] sat;
  logic [PW-1:0] pop;
  logic [SAT_CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign s2_ready = !s2_valid_q || data_out_0_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign s1_load  = data_in_0_valid && s1_ready;
  assign s2_load  = s1_valid_q && s2_ready;

  assign s1_valid_d = s1_load ? 1'b1
                    : (s2_load ? 1'b0 : s1_valid_q);
  assign s2_valid_d = s2_load ? 1'b1
                    : (data_out_0_ready ? 1'b0 : s2_valid_q);

  // Extra sign bit keeps the bias add from wrapping at the top of range.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      s1_d[i] = RW'(($signed({data_in_0[i][IW-1], data_in_0[i]})
                     + BIAS) >>> SH);
    end
  end

  always_comb begin
    logic signed [CW-1:0] wide;
    sat = '0;
    for (int i = 0; i < N; i++) begin
      wide = CW'(s1_q[i]);
      if (wide > MAX_W) begin
        dout_d[i] = MAX_O;
        sat[i]    = 1'b1;
      end else if (wide < MIN_W) begin
        dout_d[i] = MIN_O;
        sat[i]    = 1'b1;
      end else begin
        dout_d[i] = wide[OW-1:0];
      end
    end
  end

  assign pop = PW'($countones(sat));

  // Clear lands before the add so a same-cycle load still counts.
  always_comb begin
    logic [SAT_CNT_WIDTH-1:0] base;
    logic [AW-1:0] sum;
    base  = sat_clear ? '0 : cnt_q;
    sum   = AW'(base) + AW'(pop);
    cnt_d = base;
    if (s2_load) begin
      cnt_d = (sum > CNT_MAX) ? '1 : sum[SAT_CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      cnt_q      <= '0;
      for (int i = 0; i < N; i++) begin
        s1_q[i]   <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      cnt_q      <= cnt_d;
      for (int i = 0; i < N; i++) begin
        if (s1_load) s1_q[i] <= s1_d[i];
        if (s2_load) dout_q[i] <= dout_d[i];
      end
    end
  end

  assign data_in_0_ready  = s1_ready;
  assign data_out_0       = dout_q;
  assign data_out_0_valid = s2_valid_q;
  assign sat_count        = cnt_q;

endmodule
